cp0_ctrl: RTL and testbench

CP0_CTRL -- requirements
Module: cp0_ctrl

---
 rtl/cp0_ctrl_if.sv | 26 ++
 rtl/cp0_ctrl.sv | 142 ++++++++++++++
 tb/tb_cp0_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cp0_ctrl_if.sv
// rtl/cp0_ctrl_if.sv - pipeline-side bus for the CP0 controller
// master is the pipeline driving requests, slave is cp0_ctrl.
interface cp0_ctrl_if;
  logic        mtc0;
  logic        mfc0;
  logic        eret;
  logic [4:0]  rd_addr;
  logic [31:0] wdata;
  logic [4:0]  exc_code;
  logic [31:0] epc_in;
  logic [4:0]  int_in;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exl;

  modport master (
    output mtc0, mfc0, eret, rd_addr, wdata, exc_code, epc_in, int_in,
    input  rdata, redirect, redirect_pc, exl
  );

  modport slave (
    input  mtc0, mfc0, eret, rd_addr, wdata, exc_code, epc_in, int_in,
    output rdata, redirect, redirect_pc, exl
  );
endinterface

// File: rtl/cp0_ctrl.sv
// rtl/cp0_ctrl.sv - CP0 register file, timer, exception/interrupt/eret sequencing
// One event per cycle is taken; the following FLUSH cycle drives redirect and ignores all requests.
module cp0_ctrl (
  input  logic        clock,
  input  logic        reset,
  cp0_ctrl_if.slave   bus
);

  localparam logic [4:0]  REG_COUNT   = 5'd9;
  localparam logic [4:0]  REG_COMPARE = 5'd11;
  localparam logic [4:0]  REG_STATUS  = 5'd12;
  localparam logic [4:0]  REG_CAUSE   = 5'd13;
  localparam logic [4:0]  REG_EPC     = 5'd14;
  localparam logic [4:0]  NO_EXC      = 5'h1F;
  localparam logic [31:0] VECTOR_PC   = 32'h0000_F000;

  typedef enum logic [1:0] {RUN, HANDLER, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [7:0]  im_q, im_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [4:0]  ip_q, ip_d;
  logic        tp_q, tp_d;

  logic        in_flush;
  logic        int_pend;
  logic        take_event;
  logic [31:0] status_w;
  logic [31:0] cause_w;

  assign in_flush = (state_q == FLUSH);
  assign status_w = {16'h0, im_q, 6'h0, exl_q, ie_q};
  assign cause_w  = {16'h0, tp_q, ip_q, 3'h0, exc_code_q, 2'h0};
  assign int_pend = ie_q & ~exl_q & (|({tp_q, ip_q} & im_q[7:2]));

  always_comb begin
    count_d       = count_q + 32'd1;
    compare_d     = compare_q;
    epc_d         = epc_q;
    redirect_pc_d = redirect_pc_q;
    ie_d          = ie_q;
    exl_d         = exl_q;
    im_d          = im_q;
    exc_code_d    = exc_code_q;
    ip_d          = bus.int_in;
    tp_d          = tp_q | (count_q == compare_q);
    take_event    = 1'b0;

    // The flushed instruction in the redirect cycle must not change architectural state.
    if (!in_flush) begin
      if (bus.exc_code != NO_EXC) begin
        take_event    = 1'b1;
        exc_code_d    = bus.exc_code;
        exl_d         = 1'b1;
        redirect_pc_d = VECTOR_PC;
        if (!exl_q) epc_d = bus.epc_in;
      end else if (int_pend) begin
        take_event    = 1'b1;
        exc_code_d    = 5'd0;
        exl_d         = 1'b1;
        epc_d         = bus.epc_in;
        redirect_pc_d = VECTOR_PC;
      end else if (bus.eret) begin
        take_event    = 1'b1;
        exl_d         = 1'b0;
        redirect_pc_d = epc_q;
      end else if (bus.mtc0) begin
        case (bus.rd_addr)
          REG_COUNT:   count_d = bus.wdata;
          REG_COMPARE: begin
            compare_d = bus.wdata;
            tp_d      = 1'b0;
          end
          REG_STATUS: begin
            ie_d  = bus.wdata[0];
            exl_d = bus.wdata[1];
            im_d  = bus.wdata[15:8];
          end
          REG_EPC:     epc_d = bus.wdata;
          default:     ;
        endcase
      end
    end

    if (take_event)  state_d = FLUSH;
    else if (exl_d)  state_d = HANDLER;
    else             state_d = RUN;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RUN;
      count_q       <= 32'd0;
      compare_q     <= 32'hFFFF_FFFF;
      epc_q         <= 32'd0;
      redirect_pc_q <= 32'd0;
      ie_q          <= 1'b0;
      exl_q         <= 1'b0;
      im_q          <= 8'hFF;
      exc_code_q    <= 5'd0;
      ip_q          <= 5'd0;
      tp_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      compare_q     <= compare_d;
      epc_q         <= epc_d;
      redirect_pc_q <= redirect_pc_d;
      ie_q          <= ie_d;
      exl_q         <= exl_d;
      im_q          <= im_d;
      exc_code_q    <= exc_code_d;
      ip_q          <= ip_d;
      tp_q          <= tp_d;
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (bus.mfc0) begin
      case (bus.rd_addr)
        REG_COUNT:   bus.rdata = count_q;
        REG_COMPARE: bus.rdata = compare_q;
        REG_STATUS:  bus.rdata = status_w;
        REG_CAUSE:   bus.rdata = cause_w;
        REG_EPC:     bus.rdata = epc_q;
        default:     bus.rdata = 32'd0;
      endcase
    end
  end

  assign bus.redirect    = in_flush;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.exl         = exl_q;

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb/tb_cp0_ctrl.sv - cycle-by-cycle vector table for cp0_ctrl with an expected-value queue
// Each row holds one cycle's inputs and the outputs expected while those inputs are applied.
module tb_cp0_ctrl;

  localparam logic [4:0] NX = 5'h1F;

  typedef struct {
    logic        rst;
    logic        mtc0;
    logic        mfc0;
    logic        eret;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [4:0]  exc;
    logic [31:0] epc;
    logic [4:0]  intin;
    logic [31:0] e_rdata;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_exl;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  vec_t tbl[$];
  vec_t sb[$];

  cp0_ctrl_if bus ();
  cp0_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic mt, input logic mf, input logic er,
                              input logic [4:0] rd, input logic [31:0] wd, input logic [4:0] exc,
                              input logic [31:0] epc, input logic [4:0] intin,
                              input logic [31:0] e_rdata, input logic e_redir,
                              input logic [31:0] e_rpc, input logic e_exl);
    vec_t v;
    v.rst = rst; v.mtc0 = mt; v.mfc0 = mf; v.eret = er; v.rd = rd; v.wdata = wd;
    v.exc = exc; v.epc = epc; v.intin = intin;
    v.e_rdata = e_rdata; v.e_redir = e_redir; v.e_rpc = e_rpc; v.e_exl = e_exl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset        = v.rst;
    bus.mtc0     = v.mtc0;
    bus.mfc0     = v.mfc0;
    bus.eret     = v.eret;
    bus.rd_addr  = v.rd;
    bus.wdata    = v.wdata;
    bus.exc_code = v.exc;
    bus.epc_in   = v.epc;
    bus.int_in   = v.intin;
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    int   hit;

    // rst mt mf er  rd  wdata         exc  epc     int    rdata         redir rpc          exl
    tbl.push_back(mk(0,0,1,0,12,32'h0,       NX,   32'h0,   5'd0, 32'h0000FF00, 0, 32'h0,      0)); // 0 reset Status
    tbl.push_back(mk(0,0,1,0,13,32'h0,       NX,   32'h0,   5'd0, 32'h0,        0, 32'h0,      0));
    tbl.push_back(mk(0,0,1,0,11,32'h0,       NX,   32'h0,   5'd0, 32'hFFFFFFFF, 0, 32'h0,      0));
    tbl.push_back(mk(0,0,1,0, 9,32'h0,       NX,   32'h0,   5'd0, 32'd3,        0, 32'h0,      0));
    tbl.push_back(mk(0,1,1,0, 3,32'hDEADBEEF,NX,   32'h0,   5'd0, 32'h0,        0, 32'h0,      0));
    tbl.push_back(mk(0,1,1,0,12,32'h0000FF01,NX,   32'h0,   5'd0, 32'h0000FF00, 0, 32'h0,      0)); // 5 same-cycle read old
    tbl.push_back(mk(0,1,1,0,13,32'hFFFFFFFF,NX,   32'h0,   5'd0, 32'h0,        0, 32'h0,      0));
    tbl.push_back(mk(0,1,1,0,12,32'hFFFFFFFD,NX,   32'h0,   5'd0, 32'h0000FF01, 0, 32'h0,      0));
    tbl.push_back(mk(0,0,1,0,12,32'h0,       NX,   32'h0,   5'd0, 32'h0000FF01, 0, 32'h0,      0));
    tbl.push_back(mk(0,0,1,0, 3,32'h0,       5'h08,32'h100, 5'd0, 32'h0,        0, 32'h0,      0)); // 9 exception
    tbl.push_back(mk(0,0,1,1,14,32'h0,       NX,   32'h0,   5'd0, 32'h100,      1, 32'hF000,   1));
    tbl.push_back(mk(0,0,1,0,13,32'h0,       NX,   32'h0,   5'd0, 32'h20,       0, 32'hF000,   1));
    tbl.push_back(mk(0,0,1,0,12,32'h0,       5'h0C,32'hF010,5'd0, 32'h0000FF03, 0, 32'hF000,   1)); // 12 nested
    tbl.push_back(mk(0,0,0,0, 0,32'h0,       NX,   32'h0,   5'd0, 32'h0,        1, 32'hF000,   1));
    tbl.push_back(mk(0,0,1,0,14,32'h0,       NX,   32'h0,   5'd0, 32'h100,      0, 32'hF000,   1));
    tbl.push_back(mk(0,0,1,0,13,32'h0,       NX,   32'h0,   5'd0, 32'h30,       0, 32'hF000,   1));
    tbl.push_back(mk(0,0,0,1, 0,32'h0,       NX,   32'h0,   5'd0, 32'h0,        0, 32'hF000,   1)); // 16 eret
    tbl.push_back(mk(0,0,0,0, 0,32'h0,       NX,   32'h0,   5'd0, 32'h0,        1, 32'h100,    0));
    tbl.push_back(mk(0,0,1,0,12,32'h0,       NX,   32'h0,   5'd1, 32'h0000FF01, 0, 32'h100,    0));
    tbl.push_back(mk(0,0,0,1, 0,32'h0,       5'h04,32'h200, 5'd1, 32'h0,        0, 32'h100,    0)); // 19 exc+int+eret
    tbl.push_back(mk(0,0,0,1, 0,32'h0,       NX,   32'h0,   5'd0, 32'h0,        1, 32'hF000,   1));
    tbl.push_back(mk(0,0,1,0,13,32'h0,       NX,   32'h0,   5'd0, 32'h10,       0, 32'hF000,   1));
    tbl.push_back(mk(0,0,1,0,14,32'h0,       NX,   32'h0,   5'd0, 32'h200,      0, 32'hF000,   1));
    tbl.push_back(mk(0,0,0,1, 0,32'h0,       NX,   32'h0,   5'd0, 32'h0,        0, 32'hF000,   1));
    tbl.push_back(mk(0,0,0,0, 0,32'h0,       NX,   32'h0,   5'd0, 32'h0,        1, 32'h200,    0));
    tbl.push_back(mk(0,1,0,0,11,32'd30,      NX,   32'h0,   5'd0, 32'h0,        0, 32'h200,    0)); // 25 Compare=Count+5
    for (int i = 26; i < 30; i++)
      tbl.push_back(mk(0,0,0,0,0,32'h0,      NX,   32'h0,   5'd0, 32'h0,        0, 32'h200,    0));
    tbl.push_back(mk(0,0,1,0,13,32'h0,       NX,   32'h0,   5'd0, 32'h10,       0, 32'h200,    0));
    tbl.push_back(mk(0,0,1,0,13,32'h0,       NX,   32'h300, 5'd0, 32'h8010,     0, 32'h200,    0)); // 31 timer irq
    tbl.push_back(mk(0,0,0,0, 0,32'h0,       NX,   32'h0,   5'd0, 32'h0,        1, 32'hF000,   1));
    tbl.push_back(mk(0,0,1,0,13,32'h0,       NX,   32'h0,   5'd0, 32'h8000,     0, 32'hF000,   1));
    tbl.push_back(mk(0,0,1,0,14,32'h0,       NX,   32'h0,   5'd0, 32'h300,      0, 32'hF000,   1));
    tbl.push_back(mk(0,1,0,0,11,32'h0,       NX,   32'h0,   5'd0, 32'h0,        0, 32'hF000,   1));
    tbl.push_back(mk(0,0,1,0,13,32'h0,       NX,   32'h0,   5'd0, 32'h0,        0, 32'hF000,   1));
    tbl.push_back(mk(0,0,0,1, 0,32'h0,       NX,   32'h0,   5'd0, 32'h0,        0, 32'hF000,   1));
    tbl.push_back(mk(0,0,0,0, 0,32'h0,       NX,   32'h0,   5'd0, 32'h0,        1, 32'h300,    0));
    tbl.push_back(mk(0,1,0,0,11,32'h1000,    NX,   32'h0,   5'd0, 32'h0,        0, 32'h300,    0));
    tbl.push_back(mk(0,1,0,0, 9,32'hFFFFFFFE,NX,   32'h0,   5'd0, 32'h0,        0, 32'h300,    0)); // 40 Count wrap
    tbl.push_back(mk(0,0,1,0, 9,32'h0,       NX,   32'h0,   5'd0, 32'hFFFFFFFE, 0, 32'h300,    0));
    tbl.push_back(mk(0,0,1,0, 9,32'h0,       NX,   32'h0,   5'd0, 32'hFFFFFFFF, 0, 32'h300,    0));
    tbl.push_back(mk(0,0,1,0, 9,32'h0,       NX,   32'h0,   5'd0, 32'h0,        0, 32'h300,    0));
    tbl.push_back(mk(0,0,0,0, 0,32'h0,       5'h02,32'h400, 5'd0, 32'h0,        0, 32'h300,    0));
    tbl.push_back(mk(1,0,0,0,12,32'h0,       NX,   32'h0,   5'd0, 32'h0,        1, 32'hF000,   1)); // 45 reset in FLUSH
    tbl.push_back(mk(0,0,1,0,12,32'h0,       NX,   32'h0,   5'd0, 32'h0000FF00, 0, 32'h0,      0));
    tbl.push_back(mk(0,0,1,0,13,32'h0,       NX,   32'h0,   5'd0, 32'h0,        0, 32'h0,      0));
    tbl.push_back(mk(0,0,1,0,14,32'h0,       NX,   32'h0,   5'd0, 32'h0,        0, 32'h0,      0));
    tbl.push_back(mk(0,0,1,0,11,32'h0,       NX,   32'h0,   5'd0, 32'hFFFFFFFF, 0, 32'h0,      0));
    tbl.push_back(mk(0,0,1,0, 9,32'h0,       NX,   32'h0,   5'd0, 32'd4,        0, 32'h0,      0));
    tbl.push_back(mk(1,0,0,0, 0,32'h0,       5'h03,32'h500, 5'd0, 32'h0,        0, 32'h0,      0)); // 51 reset drops exc
    tbl.push_back(mk(0,0,1,0,14,32'h0,       NX,   32'h0,   5'd0, 32'h0,        0, 32'h0,      0));

    drive(mk(1,0,0,0,0,32'h0,NX,32'h0,5'd0,32'h0,0,32'h0,0));
    repeat (2) @(posedge clock);

    for (int i = 0; i < tbl.size(); i++) begin
      #1;
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clock);
      e = sb.pop_front();
      chk("rdata",       i, bus.rdata,              e.e_rdata);
      chk("redirect",    i, {31'd0, bus.redirect},  {31'd0, e.e_redir});
      chk("redirect_pc", i, bus.redirect_pc,        e.e_rpc);
      chk("exl",         i, {31'd0, bus.exl},       {31'd0, e.e_exl});
      @(posedge clock);
    end

    // Timer interrupt from a fresh reset: Status.IE on, Compare=10, redirect expected 11 cycles after the Status write.
    #1;
    drive(mk(0,1,0,0,12,32'h0000FF01,NX,32'h0,5'd0,32'h0,0,32'h0,0));
    @(posedge clock);
    #1;
    drive(mk(0,1,0,0,11,32'd10,NX,32'h0,5'd0,32'h0,0,32'h0,0));
    @(posedge clock);
    hit = -1;
    for (int h = 2; h < 60; h++) begin
      #1;
      drive(mk(0,0,0,0,0,32'h0,NX,32'h700,5'd0,32'h0,0,32'h0,0));
      @(negedge clock);
      if (bus.redirect) begin
        hit = h;
        break;
      end
      @(posedge clock);
    end
    chk("irq_cycle",    hit, hit,             32'd11);
    chk("irq_vector",   hit, bus.redirect_pc, 32'h0000F000);
    chk("irq_exl",      hit, {31'd0, bus.exl}, 32'd1);
    @(posedge clock);
    #1;
    drive(mk(0,0,1,0,14,32'h0,NX,32'h0,5'd0,32'h0,0,32'h0,0));
    @(negedge clock);
    chk("irq_one_shot", hit, {31'd0, bus.redirect}, 32'd0);
    chk("irq_epc",      hit, bus.rdata,       32'h700);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
